// File: rtl/bmp280_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bmp280_sampler                                                   |
// | Purpose : BMP280 forced-mode measurement sequencer driving a byte-level    |
// |           I2C master; assembles 20-bit raw pressure/temperature words.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bmp280_sampler #(
  parameter logic [6:0]  DEV_ADDR   = 7'h77,
  parameter logic [7:0]  CTRL_MEAS  = 8'h25,
  parameter int unsigned POLL_LIMIT = 200
) (
  input  logic        FPGA_CLK1_50,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [2:0]  cmd_op,
  output logic [7:0]  cmd_wdata,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_data,
  input  logic        rsp_nack,
  output logic [19:0] press_raw,
  output logic [19:0] temp_raw,
  output logic        sample_valid,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam logic [2:0] c_ST_IDLE       = 3'd0;
  localparam logic [2:0] c_ST_ISSUE      = 3'd1;
  localparam logic [2:0] c_ST_WAIT_RSP   = 3'd2;
  localparam logic [2:0] c_ST_NEXT       = 3'd3;
  localparam logic [2:0] c_ST_ABORT      = 3'd4;
  localparam logic [2:0] c_ST_ABORT_WAIT = 3'd5;

  localparam logic [2:0] c_OP_START     = 3'd0;
  localparam logic [2:0] c_OP_WRITE     = 3'd1;
  localparam logic [2:0] c_OP_READ_ACK  = 3'd2;
  localparam logic [2:0] c_OP_READ_NACK = 3'd3;
  localparam logic [2:0] c_OP_STOP      = 3'd4;

  localparam logic [4:0] c_STEP_POLL_FIRST  = 5'd5;
  localparam logic [4:0] c_STEP_STATUS_RD   = 5'd10;
  localparam logic [4:0] c_STEP_POLL_LAST   = 5'd11;
  localparam logic [4:0] c_STEP_BURST_FIRST = 5'd12;
  localparam logic [4:0] c_STEP_BYTE0       = 5'd17;
  localparam logic [4:0] c_STEP_LAST        = 5'd23;

  localparam logic [7:0] c_ADDR_WR    = {DEV_ADDR, 1'b0};
  localparam logic [7:0] c_ADDR_RD    = {DEV_ADDR, 1'b1};
  localparam logic [7:0] c_POLL_LIMIT = 8'(POLL_LIMIT);

  logic [2:0] r_state;
  logic [4:0] r_step;
  logic [7:0] r_poll_cnt;
  logic       r_measuring;
  logic [7:0] r_byte [0:5];

  logic [2:0] w_prog_op;
  logic [7:0] w_prog_wdata;
  logic [7:0] w_poll_next;
  logic [2:0] w_byte_idx;

  assign w_poll_next = r_poll_cnt + 8'd1;
  assign w_byte_idx  = 3'(r_step - c_STEP_BYTE0);

  // Command program: config (0-4), status poll (5-11), six-byte burst (12-23).
  always_comb begin
    w_prog_op    = c_OP_STOP;
    w_prog_wdata = 8'h00;
    case (r_step)
      5'd0, 5'd5, 5'd8, 5'd12, 5'd15: w_prog_op = c_OP_START;
      5'd1, 5'd6, 5'd13: begin w_prog_op = c_OP_WRITE; w_prog_wdata = c_ADDR_WR; end
      5'd9, 5'd16:       begin w_prog_op = c_OP_WRITE; w_prog_wdata = c_ADDR_RD; end
      5'd2:  begin w_prog_op = c_OP_WRITE; w_prog_wdata = 8'hF4;     end
      5'd3:  begin w_prog_op = c_OP_WRITE; w_prog_wdata = CTRL_MEAS; end
      5'd7:  begin w_prog_op = c_OP_WRITE; w_prog_wdata = 8'hF3;     end
      5'd14: begin w_prog_op = c_OP_WRITE; w_prog_wdata = 8'hF7;     end
      5'd10, 5'd22: w_prog_op = c_OP_READ_NACK;
      5'd17, 5'd18, 5'd19, 5'd20, 5'd21: w_prog_op = c_OP_READ_ACK;
      default: w_prog_op = c_OP_STOP;
    endcase
  end

  assign busy      = (r_state != c_ST_IDLE);
  assign cmd_valid = (r_state == c_ST_ISSUE) || (r_state == c_ST_ABORT);

  always_comb begin
    cmd_op    = c_OP_START;
    cmd_wdata = 8'h00;
    if (r_state == c_ST_ISSUE) begin
      cmd_op    = w_prog_op;
      cmd_wdata = w_prog_wdata;
    end else if (r_state == c_ST_ABORT) begin
      cmd_op    = c_OP_STOP;
    end
  end

  always_ff @(posedge FPGA_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= c_ST_IDLE;
      r_step       <= 5'd0;
      r_poll_cnt   <= 8'd0;
      r_measuring  <= 1'b0;
      for (int i = 0; i < 6; i++) r_byte[i] <= 8'h00;
      press_raw    <= 20'h0;
      temp_raw     <= 20'h0;
      sample_valid <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
    end else begin
      sample_valid <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            error      <= 1'b0;
            err_code   <= 2'd0;
            r_poll_cnt <= 8'd0;
            r_step     <= 5'd0;
            r_state    <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          if (cmd_ready) r_state <= c_ST_WAIT_RSP;
        end
        c_ST_WAIT_RSP: begin
          if (rsp_valid) begin
            if (w_prog_op == c_OP_WRITE && rsp_nack) begin
              r_state <= c_ST_ABORT;
            end else if (r_step == c_STEP_LAST) begin
              // Final STOP completes: publish straight away so the pulse lands one cycle after the response.
              press_raw    <= {r_byte[0], r_byte[1], r_byte[2][7:4]};
              temp_raw     <= {r_byte[3], r_byte[4], r_byte[5][7:4]};
              sample_valid <= 1'b1;
              r_state      <= c_ST_IDLE;
            end else begin
              if (r_step == c_STEP_STATUS_RD) r_measuring <= rsp_data[3];
              if (r_step >= c_STEP_BYTE0) r_byte[w_byte_idx] <= rsp_data;
              r_state <= c_ST_NEXT;
            end
          end
        end
        c_ST_NEXT: begin
          if (r_step == c_STEP_POLL_LAST) begin
            if (r_measuring) begin
              r_poll_cnt <= w_poll_next;
              if (w_poll_next == c_POLL_LIMIT) begin
                error    <= 1'b1;
                err_code <= 2'd2;
                r_state  <= c_ST_IDLE;
              end else begin
                r_step   <= c_STEP_POLL_FIRST;
                r_state  <= c_ST_ISSUE;
              end
            end else begin
              r_step  <= c_STEP_BURST_FIRST;
              r_state <= c_ST_ISSUE;
            end
          end else begin
            r_step  <= r_step + 5'd1;
            r_state <= c_ST_ISSUE;
          end
        end
        c_ST_ABORT: begin
          if (cmd_ready) r_state <= c_ST_ABORT_WAIT;
        end
        c_ST_ABORT_WAIT: begin
          if (rsp_valid) begin
            error    <= 1'b1;
            err_code <= 2'd1;
            r_state  <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bmp280_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bmp280_sampler                                                |
// | Purpose : Directed bench with an I2C-master/sensor model for the sampler.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bmp280_sampler;

  logic        clk = 1'b0;
  logic        reset_n, start, busy, cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_nack;
  logic [7:0]  rsp_data;
  logic [19:0] press_raw, temp_raw;
  logic        sample_valid, error;
  logic [1:0]  err_code;

  always #10 clk = ~clk;

  bmp280_sampler #(.DEV_ADDR(7'h77), .CTRL_MEAS(8'h25), .POLL_LIMIT(4)) dut (
    .FPGA_CLK1_50(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_nack(rsp_nack),
    .press_raw(press_raw), .temp_raw(temp_raw), .sample_valid(sample_valid),
    .error(error), .err_code(err_code)
  );

  typedef struct packed { logic [2:0] op; logic [7:0] wd; } cmd_t;

  int         total = 0, bad = 0;
  cmd_t       exp_q[$];
  logic [7:0] status_q[$];
  logic [7:0] stat_dflt = 8'h00;
  logic [7:0] burst [6];
  bit         inject_nack = 0, nack_done = 0, exp_sample = 0;
  int         bp = 0, end_lat = 1, cmd_count = 0, samples = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [2:0] o, input logic [7:0] w);
    cmd_t c;
    c.op = o; c.wd = w;
    exp_q.push_back(c);
  endtask
  task automatic push_config();
    push_cmd(0, 0); push_cmd(1, 8'hEE); push_cmd(1, 8'hF4); push_cmd(1, 8'h25); push_cmd(4, 0);
  endtask
  task automatic push_poll();
    push_cmd(0, 0); push_cmd(1, 8'hEE); push_cmd(1, 8'hF3);
    push_cmd(0, 0); push_cmd(1, 8'hEF); push_cmd(3, 0); push_cmd(4, 0);
  endtask
  task automatic push_burst();
    push_cmd(0, 0); push_cmd(1, 8'hEE); push_cmd(1, 8'hF7); push_cmd(0, 0); push_cmd(1, 8'hEF);
    for (int i = 0; i < 5; i++) push_cmd(2, 0);
    push_cmd(3, 0); push_cmd(4, 0);
  endtask
  task automatic set_burst(input logic [7:0] b0, b1, b2, b3, b4, b5);
    burst[0] = b0; burst[1] = b1; burst[2] = b2; burst[3] = b3; burst[4] = b4; burst[5] = b5;
  endtask

  // I2C master + sensor model, plus per-cycle output checks.
  initial begin : emu
    bit         was_ready, prev_valid, pend, pn, last_nack, is_read;
    logic [2:0] prev_op;
    logic [7:0] prev_wd, pd, reg_ptr;
    int         cd, hold, byte_i, rise_chk, end_cd, idx;
    cmd_t       e;
    cmd_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_nack = 0;
    prev_valid = 0; pend = 0; last_nack = 0; hold = 0; byte_i = 0; is_read = 0;
    reg_ptr = 0; rise_chk = 0; end_cd = 0; cd = 0; pd = 0; pn = 0; prev_op = 0; prev_wd = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cmd_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_nack = 0;
        pend = 0; prev_valid = 0; rise_chk = 0; end_cd = 0; last_nack = 0;
      end else begin
        was_ready = cmd_ready;
        if (!cmd_valid) check("idle_fields", {cmd_op, cmd_wdata}, 0);
        if (prev_valid && !was_ready) begin
          check("hold_valid", cmd_valid, 1);
          check("hold_fields", {cmd_op, cmd_wdata}, {prev_op, prev_wd});
        end
        if (sample_valid) samples++;
        if (rise_chk > 0) begin check("next_cmd_rise", cmd_valid, 1); rise_chk = 0; end
        if (rsp_valid) begin
          if (last_nack) check("abort_stop", {cmd_valid, cmd_op}, {1'b1, 3'd4});
          else if (exp_q.size() != 0) begin check("next_gap", cmd_valid, 0); rise_chk = 1; end
          else begin check("sample_timing", sample_valid, exp_sample); end_cd = end_lat; end
        end
        if (end_cd > 0) begin end_cd--; check("end_busy", busy, (end_cd == 0) ? 0 : 1); end

        rsp_valid = 0; rsp_data = 0; rsp_nack = 0;
        if (was_ready) begin
          cmd_ready = 0; pend = 1; cd = 1;
        end else if (pend) begin
          if (cd == 0) begin
            rsp_valid = 1; rsp_data = pd; rsp_nack = pn; last_nack = pn; pend = 0;
          end else cd--;
        end else if (cmd_valid) begin
          if (!prev_valid) hold = bp;
          if (hold > 0) hold--;
          else begin
            cmd_ready = 1;
            cmd_count++;
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_cmd: got op %0d wdata 0x%0h want none", cmd_op, cmd_wdata);
            end else begin
              e = exp_q.pop_front();
              check("cmd_op", cmd_op, e.op);
              check("cmd_wdata", cmd_wdata, e.wd);
            end
            pd = 0; pn = 0;
            case (cmd_op)
              3'd0: byte_i = 0;
              3'd1: begin
                if (byte_i == 0) begin
                  is_read = cmd_wdata[0];
                  if (inject_nack && !nack_done) begin pn = 1; nack_done = 1; end
                end else if (!is_read && byte_i == 1) reg_ptr = cmd_wdata;
                byte_i++;
              end
              3'd2, 3'd3: begin
                if (reg_ptr == 8'hF3) pd = (status_q.size() != 0) ? status_q.pop_front() : stat_dflt;
                else begin
                  idx = int'(reg_ptr) - 'hF7;
                  if (idx >= 0 && idx < 6) pd = burst[idx];
                end
                reg_ptr++;
              end
              default: ;
            endcase
          end
        end
        prev_valid = cmd_valid; prev_op = cmd_op; prev_wd = cmd_wdata;
      end
    end
  end

  task automatic run_meas(input bit pulse);
    int cyc;
    cmd_count = 0; samples = 0; nack_done = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_busy", busy, 1);
    check("start_cmd_valid", cmd_valid, 1);
    check("start_err_clear", {error, err_code}, 0);
    cyc = 0;
    while (busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      start = pulse && busy && (cyc % 7 == 0);
    end
    start = 0;
    if (busy) begin total++; bad++; $display("FAIL run_bound: busy got 1 want 0 after %0d cycles", cyc); end
    repeat (3) @(negedge clk);
    check("exp_left", exp_q.size(), 0);
  endtask

  task automatic check_sample(input logic [19:0] p_lit, input logic [19:0] t_lit);
    check("press_model", press_raw, {burst[0], burst[1], burst[2][7:4]});
    check("temp_model",  temp_raw,  {burst[3], burst[4], burst[5][7:4]});
    check("press_lit", press_raw, p_lit);
    check("temp_lit",  temp_raw,  t_lit);
    check("samples", samples, 1);
    check("error_ok", {error, err_code}, 0);
  endtask

  initial begin
    reset_n = 0; start = 0;
    set_burst(8'h65, 8'h5A, 8'hC0, 8'h7E, 8'hED, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_outs", {busy, cmd_valid, cmd_op, cmd_wdata, sample_valid, error, err_code}, 0);
    check("rst_data", {press_raw, temp_raw}, 0);
    reset_n = 1;
    repeat (2) @(negedge clk);

    // Nominal
    bp = 0; stat_dflt = 8'h00; inject_nack = 0; end_lat = 1; exp_sample = 1;
    push_config(); push_poll(); push_burst();
    run_meas(0);
    check("nom_cmds", cmd_count, 24);
    check_sample(20'h655AC, 20'h7EED0);

    // Polling: three "measuring" reads before ready
    set_burst(8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC);
    status_q = '{8'h08, 8'h08, 8'h08};
    push_config(); repeat (4) push_poll(); push_burst();
    run_meas(0);
    check("poll_cmds", cmd_count, 45);
    check_sample(20'h12345, 20'h789AB);

    // Address NACK on step 1
    inject_nack = 1; exp_sample = 0;
    push_cmd(0, 0); push_cmd(1, 8'hEE); push_cmd(4, 0);
    run_meas(0);
    inject_nack = 0;
    check("nack_cmds", cmd_count, 3);
    check("nack_err", {error, err_code}, {1'b1, 2'd1});
    check("nack_samples", samples, 0);
    check("nack_hold", {press_raw, temp_raw}, {20'h12345, 20'h789AB});

    // Poll timeout with POLL_LIMIT=4
    stat_dflt = 8'h08; end_lat = 2;
    push_config(); repeat (4) push_poll();
    run_meas(0);
    check("to_cmds", cmd_count, 33);
    check("to_err", {busy, error, err_code}, {1'b0, 1'b1, 2'd2});
    check("to_samples", samples, 0);

    // Backpressure with ignored start pulses
    stat_dflt = 8'h00; end_lat = 1; exp_sample = 1; bp = 10;
    set_burst(8'h65, 8'h5A, 8'hC0, 8'h7E, 8'hED, 8'h00);
    push_config(); push_poll(); push_burst();
    run_meas(1);
    check("bp_cmds", cmd_count, 24);
    check_sample(20'h655AC, 20'h7EED0);

    // Asynchronous reset at burst step 17
    bp = 0; cmd_count = 0; samples = 0;
    push_config(); push_poll(); push_burst();
    start = 1; @(negedge clk); start = 0;
    for (int i = 0; i < 2000 && cmd_count < 17; i++) begin @(negedge clk); #2; end
    check("rst_reach17", cmd_count, 17);
    reset_n = 0;
    #1;
    check("arst_outs", {busy, cmd_valid, cmd_op, cmd_wdata, sample_valid, error, err_code}, 0);
    check("arst_data", {press_raw, temp_raw}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 reset_n = 1;
    repeat (3) @(negedge clk);
    check("post_rst_quiet", {busy, cmd_valid}, 0);
    push_config(); push_poll(); push_burst();
    run_meas(0);
    check("rerun_cmds", cmd_count, 24);
    check_sample(20'h655AC, 20'h7EED0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
